// File: rtl/star_mover.sv
// Star lifecycle controller: requests a spawn from the generator, moves the star
// once per frame tick, and retires it on hit, screen exit or lifetime expiry.
module star_mover #(
  parameter int X_MAX          = 599,
  parameter int Y_MAX          = 441,
  parameter int LIFE_FRAMES    = 255,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               run,
  input  logic               hit,
  input  logic signed [10:0] Spawn_X,
  input  logic signed [10:0] Spawn_Y,
  input  logic signed [10:0] Spawn_XM,
  input  logic signed [10:0] Spawn_YM,
  output logic               spawn_en,
  output logic signed [10:0] Star_X,
  output logic signed [10:0] Star_Y,
  output logic               star_on,
  output logic               caught,
  output logic               escaped
);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, ACTIVE, DEAD} state_t;

  localparam logic signed [11:0] XLIM = 12'(X_MAX);
  localparam logic signed [11:0] YLIM = 12'(Y_MAX);
  localparam logic [8:0]         LIFE = 9'(LIFE_FRAMES);
  localparam logic [7:0]         RESP = 8'(RESPAWN_FRAMES);

  state_t             state, state_nx;
  logic               frame_clk_d, tick;
  logic signed [10:0] xm, ym;
  logic        [7:0]  life, respawn;
  logic signed [11:0] nx, ny;
  logic               off_screen, expire, zero_motion;

  assign tick = frame_clk & ~frame_clk_d;

  // 12-bit sums so a step past either edge cannot wrap back on screen
  assign nx = $signed({Star_X[10], Star_X}) + $signed({xm[10], xm});
  assign ny = $signed({Star_Y[10], Star_Y}) + $signed({ym[10], ym});
  assign off_screen  = (nx < 12'sd0) || (nx > XLIM) || (ny < 12'sd0) || (ny > YLIM);
  assign expire      = ({1'b0, life} + 9'd1) >= LIFE;
  assign zero_motion = (Spawn_XM == 11'sd0) && (Spawn_YM == 11'sd0);

  assign spawn_en = (state == REQ);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run) state_nx = REQ;
      REQ:     state_nx = LOAD;
      LOAD:    state_nx = zero_motion ? REQ : ACTIVE;
      ACTIVE:  if (hit || (tick && (off_screen || expire))) state_nx = DEAD;
      DEAD:    if (respawn == RESP) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
    if (!run) state_nx = IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      frame_clk_d <= 1'b0;
      Star_X      <= '0;
      Star_Y      <= '0;
      xm          <= '0;
      ym          <= '0;
      life        <= '0;
      respawn     <= '0;
      star_on     <= 1'b0;
      caught      <= 1'b0;
      escaped     <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_clk_d <= frame_clk;
      star_on     <= (state_nx == ACTIVE);
      caught      <= 1'b0;
      escaped     <= 1'b0;
      if (!run) begin
        life    <= '0;
        respawn <= '0;
      end else begin
        unique case (state)
          LOAD: begin
            Star_X <= Spawn_X;
            Star_Y <= Spawn_Y;
            xm     <= Spawn_XM;
            ym     <= Spawn_YM;
            life   <= '0;
          end
          ACTIVE: begin
            // a hit wins over a same-cycle tick: no move, no escape
            if (hit) begin
              caught  <= 1'b1;
              respawn <= '0;
            end else if (tick) begin
              life <= life + 8'd1;
              if (off_screen || expire) begin
                escaped <= 1'b1;
                respawn <= '0;
              end else begin
                Star_X <= nx[10:0];
                Star_Y <= ny[10:0];
              end
            end
          end
          DEAD:    if (tick) respawn <= respawn + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_star_mover.sv
// Directed bench for star_mover: default instance plus a short-life,
// zero-respawn instance for the lifetime and reject boundaries.
module tb_star_mover;

  logic               Clk = 1'b0;
  logic               Reset, frame_clk, run, run2, hit;
  logic signed [10:0] Spawn_X, Spawn_Y, Spawn_XM, Spawn_YM;
  logic               spawn_en, star_on, caught, escaped;
  logic signed [10:0] Star_X, Star_Y;
  logic               spawn_en2, star_on2, caught2, escaped2;
  logic signed [10:0] Star_X2, Star_Y2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  star_mover dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .run(run), .hit(hit),
    .Spawn_X(Spawn_X), .Spawn_Y(Spawn_Y), .Spawn_XM(Spawn_XM), .Spawn_YM(Spawn_YM),
    .spawn_en(spawn_en), .Star_X(Star_X), .Star_Y(Star_Y), .star_on(star_on),
    .caught(caught), .escaped(escaped)
  );

  star_mover #(.LIFE_FRAMES(4), .RESPAWN_FRAMES(0)) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .run(run2), .hit(hit),
    .Spawn_X(Spawn_X), .Spawn_Y(Spawn_Y), .Spawn_XM(Spawn_XM), .Spawn_YM(Spawn_YM),
    .spawn_en(spawn_en2), .Star_X(Star_X2), .Star_Y(Star_Y2), .star_on(star_on2),
    .caught(caught2), .escaped(escaped2)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic set_spawn(input int x, input int y, input int xm, input int ym);
    Spawn_X  = 11'(x);
    Spawn_Y  = 11'(y);
    Spawn_XM = 11'(xm);
    Spawn_YM = 11'(ym);
  endtask

  // step until dut's star_on rises; returns number of spawn_en cycles seen
  task automatic wait_on(input string tag, output int pulses);
    int i;
    pulses = 0;
    for (i = 0; i < 10 && !star_on; i++) begin
      if (spawn_en) pulses++;
      step();
    end
    if (!star_on) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int pulses, n;
    Reset = 1'b1; run = 1'b1; run2 = 1'b0; hit = 1'b0; frame_clk = 1'b0;
    set_spawn(0, 0, 3, 2);

    // reset with run high and frame strobe toggling
    step();
    chk("rst_outs", {spawn_en, star_on, caught, escaped}, 0);
    chk("rst_pos", Star_X + Star_Y, 0);
    frame_clk = 1'b1;
    step();
    chk("rst_outs2", {spawn_en, star_on, caught, escaped, spawn_en2, star_on2}, 0);
    frame_clk = 1'b0;
    Reset = 1'b0;

    // first spawn: single request pulse, then star at origin
    step();
    chk("req_en", spawn_en, 1);
    wait_on("spawn1", pulses);
    chk("spawn1_pulses", pulses + 1, 1 + 1);
    chk("spawn1_x", Star_X, 0);
    chk("spawn1_y", Star_Y, 0);
    repeat (10) frame();
    chk("t10_x", Star_X, 30);
    chk("t10_y", Star_Y, 20);
    repeat (189) frame();
    chk("t199_x", Star_X, 597);
    chk("t199_y", Star_Y, 398);
    chk("t199_on", star_on, 1);

    // tick 200 steps to x=600: escape, position holds
    frame_clk = 1'b1;
    step();
    chk("exit_esc", escaped, 1);
    chk("exit_caught", caught, 0);
    chk("exit_on", star_on, 0);
    chk("exit_x", Star_X, 597);
    chk("exit_y", Star_Y, 398);
    frame_clk = 1'b0;
    step();
    chk("exit_esc_1cyc", escaped, 0);

    n = 0;
    while (n < 40 && !spawn_en) begin
      frame();
      n++;
    end
    chk("respawn_ticks", n, 30);

    // hit coincident with tick 5 from the far corner
    set_spawn(599, 441, -3, -2);
    step();
    chk("load_en_low", spawn_en, 0);
    step();
    chk("hit_on", star_on, 1);
    chk("hit_start_x", Star_X, 599);
    repeat (4) frame();
    chk("hit_t4_x", Star_X, 587);
    chk("hit_t4_y", Star_Y, 433);
    frame_clk = 1'b1; hit = 1'b1;
    step();
    chk("hit_caught", caught, 1);
    chk("hit_esc", escaped, 0);
    chk("hit_x", Star_X, 587);
    chk("hit_y", Star_Y, 433);
    chk("hit_on_off", star_on, 0);
    frame_clk = 1'b0; hit = 1'b0;
    step();
    chk("hit_caught_1cyc", caught, 0);

    // run drop while active: no pulse, then fresh request
    run = 1'b0;
    step();
    run = 1'b1;
    wait_on("rerun", pulses);
    chk("rerun_pulses", pulses, 1);
    run = 1'b0; hit = 1'b1; frame_clk = 1'b1;
    step();
    chk("drop_outs", {spawn_en, star_on, caught, escaped}, 0);
    hit = 1'b0; frame_clk = 1'b0;
    step();
    chk("drop_idle", spawn_en, 0);
    run = 1'b1;
    step();
    chk("drop_rereq", spawn_en, 1);

    // reset while active
    wait_on("pre_rst", pulses);
    Reset = 1'b1;
    step();
    chk("midrst_outs", {spawn_en, star_on, caught, escaped}, 0);
    chk("midrst_pos", Star_X + Star_Y, 0);
    Reset = 1'b0;
    step();
    chk("midrst_rereq", spawn_en, 1);
    run = 1'b0;

    // short lifetime, zero respawn delay, zero-motion reject
    set_spawn(0, 0, 3, 2);
    step();
    run2 = 1'b1;
    n = 0;
    while (n < 10 && !star_on2) begin
      step();
      n++;
    end
    chk("l4_on", star_on2, 1);
    repeat (3) frame();
    chk("l4_t3_x", Star_X2, 9);
    chk("l4_t3_esc", escaped2, 0);
    frame_clk = 1'b1;
    step();
    chk("l4_esc", escaped2, 1);
    chk("l4_x", Star_X2, 9);
    chk("l4_y", Star_Y2, 6);
    frame_clk = 1'b0;
    set_spawn(0, 0, 0, 0);
    step();
    chk("r0_req", spawn_en2, 1);
    step();
    chk("rej_load", spawn_en2, 0);
    chk("rej_on", star_on2, 0);
    step();
    chk("rej_req2", spawn_en2, 1);
    chk("dut1_quiet", {spawn_en, star_on}, 0);
    run2 = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
